uart_cmd_decoder: RTL and testbench

Host-to-probe command path. It parses fixed 4-byte command frames arriving on the UART receive side and maintains the trace configuration registers: trace width, trace enable and loopback. It returns a single response byte per frame through a DataAvail-style handshake, which the top level arbitrates onto the UART transmit side alongside trace data. It sits between the UART `received`/`rx_byte`/`recv_error` outputs and the trace interface's `width` input.

---
 rtl/uart_cmd_decoder.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Command frame decoder: parses SYNC/CMD/ARG/CHK frames from the UART receiver,
// updates the trace configuration registers and returns one response byte per frame.
module uart_cmd_decoder #(
  parameter int unsigned CLOCKFRQ   = 48_000_000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       received,
  input  logic       recv_error,
  output logic       RespAvail,
  output logic [7:0] RespVal,
  input  logic       RespNext,
  output logic [2:0] width,
  output logic       trace_en,
  output logic       loopback,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int unsigned Limit = CLOCKFRQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TmoW  = $clog2(Limit + 1);

  localparam logic [7:0] Ack = 8'h06;
  localparam logic [7:0] Nak = 8'h15;

  localparam logic [7:0] CmdSetWidth    = 8'h01;
  localparam logic [7:0] CmdSetEnable   = 8'h02;
  localparam logic [7:0] CmdSetLoopback = 8'h03;
  localparam logic [7:0] CmdGetStatus   = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StGotSync,
    StGotCmd,
    StGotArg,
    StExec,
    StResp
  } state_e;

  state_e         state;
  logic [7:0]     cmd;
  logic [7:0]     arg;
  logic           chk_ok;
  logic [TmoW-1:0] tmo_cnt;
  logic [7:0]     err_inc;
  logic           byte_ok;
  logic           tmo_hit;

  // Saturating error increment, a byte that arrives with a framing error is dropped,
  // and the timeout fires after Limit cycles without a received strobe.
  always_comb begin
    err_inc = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
    byte_ok = received && !recv_error;
    tmo_hit = (tmo_cnt == TmoW'(Limit - 1));
  end

  // Busy whenever a frame is being collected, executed or answered.
  assign busy = (state != StIdle);

  // Frame FSM with configuration registers, timeout counter and response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      cmd       <= 8'h00;
      arg       <= 8'h00;
      chk_ok    <= 1'b0;
      tmo_cnt   <= '0;
      width     <= 3'd4;
      trace_en  <= 1'b1;
      loopback  <= 1'b0;
      err_cnt   <= 8'h00;
      RespAvail <= 1'b0;
      RespVal   <= 8'h00;
    end else begin
      unique case (state)
        StIdle: begin
          tmo_cnt <= '0;
          // Non-sync bytes are discarded without counting as errors.
          if (byte_ok && rx_byte == SYNC_BYTE) begin
            state <= StGotSync;
          end
        end

        StGotSync, StGotCmd, StGotArg: begin
          if (recv_error) begin
            state   <= StIdle;
            err_cnt <= err_inc;
            tmo_cnt <= '0;
          end else if (received) begin
            tmo_cnt <= '0;
            if (state == StGotSync) begin
              cmd   <= rx_byte;
              state <= StGotCmd;
            end else if (state == StGotCmd) begin
              arg   <= rx_byte;
              state <= StGotArg;
            end else begin
              chk_ok <= (rx_byte == (SYNC_BYTE ^ cmd ^ arg));
              state  <= StExec;
            end
          end else if (tmo_hit) begin
            state   <= StIdle;
            err_cnt <= err_inc;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end

        StExec: begin
          RespAvail <= 1'b1;
          state     <= StResp;
          if (!chk_ok) begin
            RespVal <= Nak;
            err_cnt <= err_inc;
          end else begin
            case (cmd)
              CmdSetWidth: begin
                if (arg == 8'd1 || arg == 8'd2 || arg == 8'd4) begin
                  width   <= arg[2:0];
                  RespVal <= Ack;
                end else begin
                  RespVal <= Nak;
                  err_cnt <= err_inc;
                end
              end
              CmdSetEnable: begin
                trace_en <= arg[0];
                RespVal  <= Ack;
              end
              CmdSetLoopback: begin
                loopback <= arg[0];
                RespVal  <= Ack;
              end
              CmdGetStatus: begin
                RespVal <= {loopback, trace_en, 3'b000, width};
              end
              default: begin
                RespVal <= Nak;
                err_cnt <= err_inc;
              end
            endcase
          end
        end

        StResp: begin
          // Bytes arriving here are dropped; RespVal holds until consumed.
          if (RespNext) begin
            RespAvail <= 1'b0;
            state     <= StIdle;
          end
        end

        default: begin
          state     <= StIdle;
          RespAvail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (timeout shortened to 20 cycles).
module tb_uart_cmd_decoder;

  localparam int unsigned Tmo = 20;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       received;
  logic       recv_error;
  logic       RespAvail;
  logic [7:0] RespVal;
  logic       RespNext;
  logic [2:0] width;
  logic       trace_en;
  logic       loopback;
  logic [7:0] err_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_bad;
  logic [7:0] bp_bytes [4] = '{8'hA5, 8'h04, 8'h00, 8'hA1};

  uart_cmd_decoder #(
    .CLOCKFRQ  (1_000_000),
    .TIMEOUT_US(Tmo),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .received  (received),
    .recv_error(recv_error),
    .RespAvail (RespAvail),
    .RespVal   (RespVal),
    .RespNext  (RespNext),
    .width     (width),
    .trace_en  (trace_en),
    .loopback  (loopback),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    tick(1);
    received = 1'b0;
  endtask

  // Sends a full frame and waits until the response should be available.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(k);
    tick(1);
  endtask

  task automatic take_resp();
    RespNext = 1'b1;
    tick(1);
    RespNext = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    rx_byte    = 8'h00;
    received   = 1'b0;
    recv_error = 1'b0;
    RespNext   = 1'b0;

    // Reset values
    tick(3);
    rst = 1'b1;
    tick(1);
    check_eq("rst_width", width, 3'd4);
    check_eq("rst_trace_en", trace_en, 1'b1);
    check_eq("rst_loopback", loopback, 1'b0);
    check_eq("rst_err_cnt", err_cnt, 8'h00);
    check_eq("rst_resp_avail", RespAvail, 1'b0);
    check_eq("rst_resp_val", RespVal, 8'h00);
    check_eq("rst_busy", busy, 1'b0);

    // Set width 2 with exact response latency
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hA6);
    check_eq("sw_avail_exec", RespAvail, 1'b0);
    check_eq("sw_busy_exec", busy, 1'b1);
    tick(1);
    check_eq("sw_avail", RespAvail, 1'b1);
    check_eq("sw_val", RespVal, 8'h06);
    check_eq("sw_width", width, 3'd2);
    take_resp();
    check_eq("sw_avail_done", RespAvail, 1'b0);
    check_eq("sw_busy_done", busy, 1'b0);

    // Width back to 4, then bad ARG, then status
    send_frame(8'h01, 8'h04, 8'hA0);
    check_eq("sw4_val", RespVal, 8'h06);
    check_eq("sw4_width", width, 3'd4);
    take_resp();
    send_frame(8'h01, 8'h03, 8'hA7);
    check_eq("badarg_val", RespVal, 8'h15);
    check_eq("badarg_err", err_cnt, 8'd1);
    check_eq("badarg_width", width, 3'd4);
    take_resp();
    send_frame(8'h04, 8'h00, 8'hA1);
    check_eq("status_val", RespVal, 8'h44);
    check_eq("status_err", err_cnt, 8'd1);
    take_resp();

    // Bad checksum, then stray bytes in idle
    send_frame(8'h02, 8'h00, 8'h00);
    check_eq("badchk_val", RespVal, 8'h15);
    check_eq("badchk_trace_en", trace_en, 1'b1);
    check_eq("badchk_err", err_cnt, 8'd2);
    take_resp();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    tick(1);
    check_eq("stray_busy", busy, 1'b0);
    check_eq("stray_err", err_cnt, 8'd2);
    check_eq("stray_avail", RespAvail, 1'b0);

    // Timeout: still collecting one cycle before the limit, idle at the limit
    send_byte(8'hA5);
    send_byte(8'h02);
    tick(Tmo - 1);
    check_eq("tmo_busy_before", busy, 1'b1);
    tick(1);
    check_eq("tmo_busy", busy, 1'b0);
    check_eq("tmo_err", err_cnt, 8'd3);
    check_eq("tmo_avail", RespAvail, 1'b0);

    // Framing error after sync
    send_byte(8'hA5);
    recv_error = 1'b1;
    tick(1);
    recv_error = 1'b0;
    check_eq("ferr_busy", busy, 1'b0);
    check_eq("ferr_err", err_cnt, 8'd4);

    // recv_error together with received in GOT_CMD
    send_byte(8'hA5);
    send_byte(8'h02);
    recv_error = 1'b1;
    send_byte(8'h00);
    recv_error = 1'b0;
    check_eq("both_busy", busy, 1'b0);
    check_eq("both_err", err_cnt, 8'd5);

    // recv_error in idle is ignored
    recv_error = 1'b1;
    tick(1);
    recv_error = 1'b0;
    check_eq("idle_ferr_err", err_cnt, 8'd5);

    // Back-pressure: response held for 100 cycles while a new frame is dropped
    send_frame(8'h02, 8'h01, 8'hA6);
    check_eq("bp_val", RespVal, 8'h06);
    bp_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0 && i < 40) begin
        received = 1'b1;
        rx_byte  = bp_bytes[i / 10];
      end
      tick(1);
      received = 1'b0;
      if (RespAvail !== 1'b1 || RespVal !== 8'h06) bp_bad++;
    end
    check_eq("bp_stable", bp_bad, 0);
    check_eq("bp_err", err_cnt, 8'd5);
    take_resp();
    tick(3);
    check_eq("bp_no_queue_avail", RespAvail, 1'b0);
    check_eq("bp_no_queue_busy", busy, 1'b0);

    // RespNext with nothing pending is ignored
    RespNext = 1'b1;
    tick(1);
    RespNext = 1'b0;
    check_eq("spurious_next_busy", busy, 1'b0);

    // Change config so reset is visible, then reset in GOT_ARG
    send_frame(8'h03, 8'h01, 8'hA7);
    check_eq("lb_loopback", loopback, 1'b1);
    take_resp();
    send_frame(8'h02, 8'h00, 8'hA7);
    check_eq("en_trace_en", trace_en, 1'b0);
    take_resp();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_width", width, 3'd4);
    check_eq("mid_rst_trace_en", trace_en, 1'b1);
    check_eq("mid_rst_loopback", loopback, 1'b0);
    check_eq("mid_rst_err", err_cnt, 8'h00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_avail", RespAvail, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
